// File: rtl/rx_token_decoder.sv
// Receive decoder for USB token, SOF and handshake packets: PID complement, length and CRC5 checks.
// Optional build macro RX_ADDR_FILTER_EN rejects OUT/IN/SETUP tokens not addressed to dev_addr.

module rx_token_decoder #(
    parameter int TOKEN_BYTES = 3,
    parameter int ERR_CODE_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_byte_valid,
    input  logic                  rx_sop,
    input  logic                  rx_eop,
    input  logic                  rx_handshake_on,
    input  logic [6:0]            dev_addr,
    output logic                  rx_pid_en,
    output logic [3:0]            rx_pid,
    output logic [10:0]           rx_token_field,
    output logic                  rx_err,
    output logic [ERR_CODE_W-1:0] rx_err_code
);

    // Token body is the bytes after the PID minus the 5 CRC bits.
    localparam int FIELD_W = (TOKEN_BYTES - 1) * 8 - 5;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

    localparam logic [ERR_CODE_W-1:0] ERR_PID  = ERR_CODE_W'(0);
    localparam logic [ERR_CODE_W-1:0] ERR_LEN  = ERR_CODE_W'(1);
    localparam logic [ERR_CODE_W-1:0] ERR_CRC  = ERR_CODE_W'(2);
    localparam logic [ERR_CODE_W-1:0] ERR_ADDR = ERR_CODE_W'(3);

    typedef enum logic [2:0] {IDLE, TOK1, TOK2, HS_END, SKIP, END_WAIT} state_t;
    typedef enum logic [1:0] {PC_TOKEN, PC_HANDSHAKE, PC_DATA, PC_BAD} pid_class_t;

    function automatic pid_class_t classify(input logic [7:0] b);
        pid_class_t cls;
        if (b[7:4] != ~b[3:0]) begin
            cls = PC_BAD;
        end else begin
            case (b[3:0])
                PID_OUT, PID_IN, PID_SETUP, PID_SOF: cls = PC_TOKEN;
                PID_ACK, PID_NAK, PID_STALL:         cls = PC_HANDSHAKE;
                PID_DATA0, PID_DATA1:                cls = PC_DATA;
                default:                             cls = PC_BAD;
            endcase
        end
        return cls;
    endfunction

    // Returns the CRC5 as it appears on the wire: inverted residue, bit-reversed.
    function automatic logic [4:0] crc5_wire(input logic [FIELD_W-1:0] f);
        logic [4:0] c;
        logic [4:0] res;
        logic       fb;
        c = 5'b11111;
        for (int i = 0; i < FIELD_W; i++) begin
            fb = f[i] ^ c[4];
            c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
        end
        for (int i = 0; i < 5; i++) res[i] = ~c[4-i];
        return res;
    endfunction

    state_t                state_q, state_d;
    logic [3:0]            pid_q, pid_d;
    logic [FIELD_W-1:0]    field_q, field_d;
    logic [4:0]            crc_q, crc_d;
    logic                  skip_err_q, skip_err_d;
    logic [ERR_CODE_W-1:0] skip_code_q, skip_code_d;
    logic                  pid_en_d, err_d, field_load_d;
    logic [ERR_CODE_W-1:0] err_code_d;
    logic                  addr_reject;

`ifdef RX_ADDR_FILTER_EN
    assign addr_reject = (pid_q != PID_SOF) && (field_q[6:0] != dev_addr);
`else
    logic unused_dev_addr;
    assign addr_reject     = 1'b0;
    assign unused_dev_addr = ^dev_addr;
`endif

    // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        pid_d        = pid_q;
        field_d      = field_q;
        crc_d        = crc_q;
        skip_err_d   = skip_err_q;
        skip_code_d  = skip_code_q;
        pid_en_d     = 1'b0;
        err_d        = 1'b0;
        err_code_d   = '0;
        field_load_d = 1'b0;

        if (rx_sop && rx_byte_valid) begin
            // A start-of-packet byte always restarts decoding, dropping any packet in progress.
            pid_d       = rx_byte[3:0];
            skip_err_d  = 1'b0;
            skip_code_d = '0;
            case (classify(rx_byte))
                PC_TOKEN:     state_d = TOK1;
                PC_HANDSHAKE: state_d = HS_END;
                PC_DATA:      state_d = SKIP;
                default: begin
                    state_d     = SKIP;
                    skip_err_d  = 1'b1;
                    skip_code_d = ERR_PID;
                end
            endcase
        end else begin
            case (state_q)
                IDLE: ;
                TOK1: begin
                    if (rx_byte_valid) begin
                        field_d[7:0] = rx_byte;
                        state_d      = TOK2;
                    end else if (rx_eop) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_LEN;
                        state_d    = IDLE;
                    end
                end
                TOK2: begin
                    if (rx_byte_valid) begin
                        field_d[FIELD_W-1:8] = rx_byte[FIELD_W-9:0];
                        crc_d                = rx_byte[7:FIELD_W-8];
                        state_d              = END_WAIT;
                    end else if (rx_eop) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_LEN;
                        state_d    = IDLE;
                    end
                end
                END_WAIT: begin
                    if (rx_byte_valid) begin
                        skip_err_d  = 1'b1;
                        skip_code_d = ERR_LEN;
                        state_d     = SKIP;
                    end else if (rx_eop) begin
                        state_d = IDLE;
                        if (crc_q != crc5_wire(field_q)) begin
                            err_d      = 1'b1;
                            err_code_d = ERR_CRC;
                        end else if (addr_reject) begin
                            err_d      = 1'b1;
                            err_code_d = ERR_ADDR;
                        end else begin
                            pid_en_d     = 1'b1;
                            field_load_d = 1'b1;
                        end
                    end
                end
                HS_END: begin
                    if (rx_byte_valid) begin
                        skip_err_d  = 1'b1;
                        skip_code_d = ERR_LEN;
                        state_d     = SKIP;
                    end else if (rx_eop) begin
                        pid_en_d = rx_handshake_on;
                        state_d  = IDLE;
                    end
                end
                SKIP: begin
                    // Errors found mid-packet are held here and reported only once the packet ends.
                    if (rx_eop) begin
                        err_d      = skip_err_q;
                        err_code_d = skip_code_q;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            pid_q          <= '0;
            field_q        <= '0;
            crc_q          <= '0;
            skip_err_q     <= 1'b0;
            skip_code_q    <= '0;
            rx_pid_en      <= 1'b0;
            rx_err         <= 1'b0;
            rx_err_code    <= '0;
            rx_pid         <= '0;
            rx_token_field <= '0;
        end else begin
            state_q     <= state_d;
            pid_q       <= pid_d;
            field_q     <= field_d;
            crc_q       <= crc_d;
            skip_err_q  <= skip_err_d;
            skip_code_q <= skip_code_d;
            rx_pid_en   <= pid_en_d;
            rx_err      <= err_d;
            rx_err_code <= err_code_d;
            if (pid_en_d)     rx_pid         <= pid_q;
            // Handshakes carry no field, so the last token field stays visible.
            if (field_load_d) rx_token_field <= field_q;
        end
    end

endmodule

// File: doc/rx_token_decoder.md
Name: rx_token_decoder

Overview:
Receive-side decoder for non-data USB packets (tokens, SOF, handshakes). Takes the byte stream from the receive deserializer and checks PID complement, packet length and CRC5. Emits a validated 4-bit PID with a one-cycle pulse to link_control, plus the 11-bit token field. DATA0/DATA1 packets are ignored here; the CRC16 receive path handles them.

Parameters:
TOKEN_BYTES, 3, total token/SOF length in bytes including PID; fixed by protocol, must not be changed.
ERR_CODE_W, 2, width of rx_err_code.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx_byte  in  8  received byte, LSB = first bit on wire
rx_byte_valid  in  1  rx_byte valid this cycle
rx_sop  in  1  asserted together with the first rx_byte_valid of a packet
rx_eop  in  1  one-cycle pulse after the last byte; rx_byte_valid is low in that cycle
rx_handshake_on  in  1  handshake reception window from link_control
dev_addr  in  7  own device address; used only with the optional feature
rx_pid_en  out  1  one-cycle pulse: valid packet finished
rx_pid  out  4  PID of the last valid packet; held until the next valid packet
rx_token_field  out  11  {endp[3:0], addr[6:0]} or SOF frame number; held like rx_pid
rx_err  out  1  one-cycle pulse: packet rejected
rx_err_code  out  ERR_CODE_W  0 = PID check, 1 = length, 2 = CRC5, 3 = address mismatch

Behaviour:
- Interface: one clock, `clk`. `rst` is synchronous and active-high.
- Reset values: all outputs 0, FSM in IDLE.
- PID byte check: rx_byte[7:4] must equal ~rx_byte[3:0]. PID = rx_byte[3:0].
- PID classes:
  - token: OUT 0001, IN 1001, SETUP 1101, SOF 0101.
  - handshake: ACK 0010, NAK 1010, STALL 1110.
  - data: 0011, 1011.
  - any other PID is a PID error.
- FSM states: IDLE, TOK1, TOK2, HS_END, SKIP, END_WAIT.
  - IDLE + rx_sop & rx_byte_valid:
    - PID check fails -> rx_err code 0, go to SKIP.
    - token -> TOK1.
    - handshake -> HS_END.
    - data -> SKIP, no output.
  - TOK1 + byte -> store field[7:0], go to TOK2.
  - TOK2 + byte -> field[10:8] = byte[2:0], crc_rx = byte[7:3] (crc bit0 at byte[3]), go to END_WAIT.
  - END_WAIT + rx_eop -> CRC check. Pass -> rx_pid_en; fail -> rx_err code 2. Go to IDLE.
  - END_WAIT + another byte -> length error (code 1), go to SKIP.
  - TOK1/TOK2 + rx_eop -> length error (code 1), go to IDLE.
  - HS_END + rx_eop:
    - rx_handshake_on = 1 -> rx_pid_en.
    - rx_handshake_on = 0 -> silently dropped.
    - Go to IDLE.
  - HS_END + byte -> length error (code 1), go to SKIP.
  - SKIP + rx_eop -> IDLE, no output.
- CRC5:
  - Register c[4:0], init 5'b11111.
  - Per field bit d, LSB first over 11 bits: fb = d ^ c[4]; c = {c[3:0],0} ^ (fb ? 5'b00101 : 0).
  - Expected wire CRC = ~c, bit-reversed so that crc_rx[0] = ~c[4].
  - Bit-serial or parallel implementation is allowed; the result must be identical.
- Latency: rx_pid_en / rx_err pulse exactly 1 cycle after the rx_eop cycle. rx_pid and rx_token_field update in the same cycle as the pulse.
- rx_pid_en and rx_err are never asserted together.
- rx_sop in any non-IDLE state: abort the current packet silently and restart decoding on that byte.
- rst mid-packet: return to IDLE, no pulse.
- rx_eop while IDLE: ignored.

Optional Feature:
Macro RX_ADDR_FILTER_EN.
- Defined: for OUT/IN/SETUP tokens with CRC pass, if addr != dev_addr, rx_err pulses with code 3 and there is no rx_pid_en. rx_pid and rx_token_field are not updated. SOF and handshakes are unaffected.
- Undefined: dev_addr is unused and code 3 never occurs.

Test Plan:
- SETUP 0x2D, 0x15, 0xBF, then rx_eop -> 1 cycle later rx_pid_en = 1, rx_pid = 1101, rx_token_field = 0x715.
- Same packet with last byte 0xB7 (corrupt CRC) -> rx_err = 1, rx_err_code = 2, rx_pid stays at the previous value.
- ACK 0xD2 then rx_eop: rx_handshake_on = 1 -> rx_pid_en, rx_pid = 0010. With rx_handshake_on = 0 -> no pulse on either output.
- Byte 0x3D (bad complement) -> rx_err code 0 at rx_eop+1. IN 0x69 with only one more byte then rx_eop -> rx_err code 1.
- DATA0 0xC3 followed by 10 bytes -> no outputs. rx_sop + 0x69 asserted while in TOK2 -> the new IN packet decodes correctly.
- RX_ADDR_FILTER_EN, dev_addr = 0x05, SETUP packet above (addr 0x15) -> rx_err code 3. Same packet with dev_addr = 0x15 -> rx_pid_en.
